mem_port_arbiter: RTL and testbench

- Shares the single byte-wide RAM port between instruction fetch (IF) and the load/store stage (MEM).
- Serialises each 1/2/4-byte access into byte cycles.
- Assembles read data and returns a one-cycle done pulse to the owner.
- Drives the per-stage stall requests consumed by the pipeline stall controller.

---
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-wide RAM port between instruction fetch
// and the load/store stage. Each 1/2/4-byte access is split into byte cycles.
// Read data is assembled little-endian, and the owner gets a one-cycle done pulse.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants when both stages are
// pending. Without it, MEM has fixed priority.
module mem_port_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [31:0]       if_data_o,
  output logic              if_done_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_len_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_done_o,
  input  logic              flush_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [7:0]        ram_dout_o,
  input  logic [7:0]        ram_din_i,
  output logic              stallreq_if_o,
  output logic              stallreq_mem_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MEM} owner_t;

  state_t            state;
  owner_t            owner;
  logic [ADDR_W-1:0] base;
  logic [2:0]        n;
  logic [1:0]        cnt;
  logic              we;
  logic [31:0]       wdata;
  logic [31:0]       data;

  logic              grant_mem, grant_if;
  logic [2:0]        len_n, n_m1;
  logic [1:0]        cnt_p1, cnt_m1;
  logic [31:0]       data_fin;
  logic              last_byte, abort;

  assign stallreq_if_o  = if_req_i & ~if_done_o;
  assign stallreq_mem_o = mem_req_i & ~mem_done_o;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_mem;  // 1: most recent grant went to MEM
  assign grant_mem = mem_req_i & (~if_req_i | ~last_mem);

  // Remember who was granted last, so ties alternate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_mem <= 1'b0;
    else if (state == IDLE && (mem_req_i || if_req_i))
      last_mem <= grant_mem;
  end
`else
  assign grant_mem = mem_req_i;
`endif
  assign grant_if = if_req_i & ~grant_mem;

  assign len_n     = (mem_len_i == 2'b00) ? 3'd1 : (mem_len_i == 2'b01) ? 3'd2 : 3'd4;
  assign n_m1      = n - 3'd1;
  assign cnt_p1    = cnt + 2'd1;
  assign cnt_m1    = cnt - 2'd1;
  assign last_byte = ({1'b0, cnt} == n_m1);
  // Only instruction fetches are abortable; a MEM access always completes.
  assign abort     = flush_i && (owner == OWN_IF);
  // The last byte arrives during WAIT; data was cleared at grant, so OR-ing it in is enough.
  assign data_fin  = data | ({24'd0, ram_din_i} << {n_m1, 3'b000});

  // Access sequencer. RAM-side and done outputs are registered so each
  // output is valid for the whole cycle of the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= OWN_NONE;
      base        <= '0;
      n           <= 3'd0;
      cnt         <= 2'd0;
      we          <= 1'b0;
      wdata       <= 32'd0;
      data        <= 32'd0;
      if_data_o   <= 32'd0;
      if_done_o   <= 1'b0;
      mem_rdata_o <= 32'd0;
      mem_done_o  <= 1'b0;
      ram_addr_o  <= '0;
      ram_we_o    <= 1'b0;
      ram_dout_o  <= 8'd0;
    end else begin
      if_done_o  <= 1'b0;
      mem_done_o <= 1'b0;
      case (state)
        IDLE: begin
          cnt        <= 2'd0;
          ram_addr_o <= '0;
          ram_we_o   <= 1'b0;
          ram_dout_o <= 8'd0;
          if (grant_mem || grant_if) begin
            owner      <= grant_mem ? OWN_MEM : OWN_IF;
            base       <= grant_mem ? mem_addr_i : if_addr_i;
            n          <= grant_mem ? len_n : 3'd4;
            we         <= grant_mem & mem_we_i;
            wdata      <= mem_wdata_i;
            data       <= 32'd0;
            // First byte goes out in the first ACCESS cycle.
            ram_addr_o <= grant_mem ? mem_addr_i : if_addr_i;
            ram_we_o   <= grant_mem & mem_we_i;
            ram_dout_o <= (grant_mem & mem_we_i) ? mem_wdata_i[7:0] : 8'd0;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (abort) begin
            state      <= IDLE;
            owner      <= OWN_NONE;
            ram_addr_o <= '0;
            ram_we_o   <= 1'b0;
            ram_dout_o <= 8'd0;
          end else begin
            if (cnt != 2'd0)
              data[{cnt_m1, 3'b000} +: 8] <= ram_din_i;
            cnt <= cnt_p1;
            if (last_byte) begin
              ram_addr_o <= '0;
              ram_we_o   <= 1'b0;
              ram_dout_o <= 8'd0;
              if (we) begin
                state      <= DONE;
                mem_done_o <= 1'b1;
              end else begin
                state <= WAIT;
              end
            end else begin
              ram_addr_o <= base + {{(ADDR_W-2){1'b0}}, cnt_p1};
              ram_we_o   <= we;
              ram_dout_o <= we ? wdata[{cnt_p1, 3'b000} +: 8] : 8'd0;
            end
          end
        end
        WAIT: begin
          if (abort) begin
            state <= IDLE;
            owner <= OWN_NONE;
          end else begin
            state <= DONE;
            if (owner == OWN_IF) begin
              if_data_o <= data_fin;
              if_done_o <= 1'b1;
            end else begin
              mem_rdata_o <= data_fin;
              mem_done_o  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          owner <= OWN_NONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a scoreboard. Stimulus pushes
// the expected done events and RAM writes. A negedge monitor pops and compares them.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              if_req_i = 1'b0;
  logic [ADDR_W-1:0] if_addr_i = '0;
  logic [31:0]       if_data_o;
  logic              if_done_o;
  logic              mem_req_i = 1'b0;
  logic              mem_we_i = 1'b0;
  logic [1:0]        mem_len_i = 2'b00;
  logic [ADDR_W-1:0] mem_addr_i = '0;
  logic [31:0]       mem_wdata_i = 32'd0;
  logic [31:0]       mem_rdata_o;
  logic              mem_done_o;
  logic              flush_i = 1'b0;
  logic [ADDR_W-1:0] ram_addr_o;
  logic              ram_we_o;
  logic [7:0]        ram_dout_o;
  logic [7:0]        ram_din_i = 8'd0;
  logic              stallreq_if_o;
  logic              stallreq_mem_o;

  mem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_done_o(if_done_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_len_i(mem_len_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
    .flush_i(flush_i), .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_dout_o(ram_dout_o),
    .ram_din_i(ram_din_i), .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Small RAM model: the few addresses used map onto 16 distinct slots.
  logic       tb_clr = 1'b1;
  logic [7:0] wbuf [16];
  logic       wval [16];

  function automatic int ridx(logic [31:0] a);
    return int'({a[9:8], a[1:0]});
  endfunction

  function automatic logic [7:0] init_byte(int i);
    case (i)
      4: return 8'h11;  5: return 8'h22;  6: return 8'h33;  7: return 8'h44;
      11: return 8'h80; 14: return 8'hA1; 1: return 8'hD4;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] rd_byte(logic [31:0] a);
    int i = ridx(a);
    return wval[i] ? wbuf[i] : init_byte(i);
  endfunction

  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 16; i++) wval[i] <= 1'b0;
    end else if (ram_we_o) begin
      wbuf[ridx(ram_addr_o)] <= ram_dout_o;
      wval[ridx(ram_addr_o)] <= 1'b1;
    end
    ram_din_i <= rd_byte(ram_addr_o);
  end

  typedef struct {bit is_mem; bit chk_data; logic [31:0] data; int at;} done_t;
  typedef struct {logic [31:0] addr; logic [7:0] b;} wr_t;
  done_t dq[$];
  wr_t   wq[$];
  done_t d_exp;
  wr_t   w_exp;
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_done(bit is_mem, bit chk_data, logic [31:0] data, int at);
    done_t d;
    d.is_mem = is_mem; d.chk_data = chk_data; d.data = data; d.at = at;
    dq.push_back(d);
  endtask

  task automatic push_wr(logic [31:0] a, logic [7:0] b);
    wr_t w;
    w.addr = a; w.b = b;
    wq.push_back(w);
  endtask

  // Monitor: every RAM write and every done pulse must match the next expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_we_o) begin
        if (wq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_write: got addr %h byte %h expected no write", ram_addr_o, ram_dout_o);
        end else begin
          w_exp = wq.pop_front();
          chk("wr_addr", ram_addr_o, w_exp.addr);
          chk("wr_byte", {24'd0, ram_dout_o}, {24'd0, w_exp.b});
        end
      end
      if (if_done_o || mem_done_o) begin
        if (dq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_done: got if_done=%0b mem_done=%0b expected none", if_done_o, mem_done_o);
        end else begin
          d_exp = dq.pop_front();
          chk("done_owner_mem", {31'd0, mem_done_o}, {31'd0, d_exp.is_mem});
          chk("done_owner_if", {31'd0, if_done_o}, {31'd0, ~d_exp.is_mem});
          chk("done_cycle", 32'(cyc), 32'(d_exp.at));
          if (d_exp.chk_data) chk("done_data", d_exp.is_mem ? mem_rdata_o : if_data_o, d_exp.data);
          if (!d_exp.is_mem) chk("stallreq_if_in_done", {31'd0, stallreq_if_o}, 32'd0);
          else               chk("stallreq_mem_in_done", {31'd0, stallreq_mem_o}, 32'd0);
        end
      end
    end
  end

  // Wait (bounded) for the done pulse, then drop the request in the following cycle.
  task automatic wait_done(bit is_mem);
    int  t = 0;
    bit  seen = 0;
    while (!seen && t < 40) begin
      @(negedge clk);
      t++;
      seen = is_mem ? mem_done_o : if_done_o;
    end
    if (!seen) begin
      n_chk++; n_fail++;
      $display("FAIL timeout_%s: got no done expected done within 40 cycles", is_mem ? "mem" : "if");
    end
    @(posedge clk); #1;
    if (is_mem) mem_req_i = 1'b0; else if_req_i = 1'b0;
  endtask

  task automatic mem_access(bit we, logic [1:0] len, logic [31:0] addr, logic [31:0] wd,
                            int lat, bit chk_data, logic [31:0] exp);
    mem_we_i = we; mem_len_i = len; mem_addr_i = addr; mem_wdata_i = wd; mem_req_i = 1'b1;
    push_done(1'b1, chk_data, exp, cyc + lat);
    #1 chk("stallreq_mem_busy", {31'd0, stallreq_mem_o}, 32'd1);
    wait_done(1'b1);
  endtask

  task automatic if_fetch(logic [31:0] addr, logic [31:0] exp);
    if_addr_i = addr; if_req_i = 1'b1;
    push_done(1'b0, 1'b1, exp, cyc + 6);
    #1 chk("stallreq_if_busy", {31'd0, stallreq_if_o}, 32'd1);
    wait_done(1'b0);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_ram_addr"}, ram_addr_o, 32'd0);
    chk({tag, "_ram_we"}, {31'd0, ram_we_o}, 32'd0);
    chk({tag, "_ram_dout"}, {24'd0, ram_dout_o}, 32'd0);
    chk({tag, "_done"}, {30'd0, if_done_o, mem_done_o}, 32'd0);
    chk({tag, "_if_data"}, if_data_o, 32'd0);
    chk({tag, "_mem_rdata"}, mem_rdata_o, 32'd0);
    chk({tag, "_stall"}, {30'd0, stallreq_if_o, stallreq_mem_o}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test expected finish before 100000 time units");
    $fatal(1);
  end

  initial begin
    int t;
    repeat (3) @(posedge clk); #1;
    chk_all_zero("reset");
    rst_n = 1'b1; tb_clr = 1'b0;
    @(posedge clk); #1;

    // IF word fetch: bytes 11,22,33,44 at 0x100..0x103
    if_fetch(32'h100, 32'h44332211);
    // MEM byte load 0x203 holding 0x80
    mem_access(1'b0, 2'b00, 32'h203, 32'd0, 3, 1'b1, 32'h00000080);
    // MEM word store 0xDEADBEEF at 0x200
    push_wr(32'h200, 8'hEF); push_wr(32'h201, 8'hBE);
    push_wr(32'h202, 8'hAD); push_wr(32'h203, 8'hDE);
    mem_access(1'b1, 2'b10, 32'h200, 32'hDEADBEEF, 5, 1'b0, 32'd0);
    // Half load reads back the low two stored bytes
    mem_access(1'b0, 2'b01, 32'h200, 32'd0, 4, 1'b1, 32'h0000BEEF);
    // len=11 is a word
    mem_access(1'b0, 2'b11, 32'h200, 32'd0, 6, 1'b1, 32'hDEADBEEF);
    // Byte store uses only the low data byte
    push_wr(32'h300, 8'h5A);
    mem_access(1'b1, 2'b00, 32'h300, 32'hFFFFFF5A, 2, 1'b0, 32'd0);
    // Half store across the top of the address space
    push_wr(32'hFFFFFFFF, 8'h34); push_wr(32'h00000000, 8'h12);
    mem_access(1'b1, 2'b01, 32'hFFFFFFFF, 32'h00001234, 3, 1'b0, 32'd0);
    // Wrapping fetch: A1 @FFFFFFFE, 34 @FFFFFFFF, 12 @0, D4 @1
    if_fetch(32'hFFFFFFFE, 32'hD41234A1);

    // Simultaneous requests: MEM first, IF granted in the IDLE after MEM's DONE
    t = cyc;
    mem_we_i = 1'b0; mem_len_i = 2'b00; mem_addr_i = 32'h300; mem_req_i = 1'b1;
    if_addr_i = 32'h100; if_req_i = 1'b1;
    push_done(1'b1, 1'b1, 32'h0000005A, t + 3);
    push_done(1'b0, 1'b1, 32'h44332211, t + 3 + 1 + 6);
    #1 chk("stallreq_if_while_mem", {31'd0, stallreq_if_o}, 32'd1);
    fork
      wait_done(1'b1);
      wait_done(1'b0);
    join

    // Flush in the third ACCESS cycle of a fetch aborts it
    if_addr_i = 32'h100; if_req_i = 1'b1;
    repeat (3) @(posedge clk); #1;
    flush_i = 1'b1; if_req_i = 1'b0;
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    chk("flush_idle_addr", ram_addr_o, 32'd0);
    chk("flush_idle_we", {31'd0, ram_we_o}, 32'd0);
    chk("flush_if_data_held", if_data_o, 32'h44332211);
    @(posedge clk); #1;
    push_wr(32'h301, 8'h77);
    mem_access(1'b1, 2'b00, 32'h301, 32'h00000077, 2, 1'b0, 32'd0);

    // Reset during a word store after two bytes have been written
    push_wr(32'h200, 8'h0D); push_wr(32'h201, 8'hF0);
    mem_we_i = 1'b1; mem_len_i = 2'b10; mem_addr_i = 32'h200; mem_wdata_i = 32'hCAFEF00D;
    mem_req_i = 1'b1;
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b0; mem_req_i = 1'b0;
    #1 chk_all_zero("midreset");
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_reset_idle", {31'd0, ram_we_o} | ram_addr_o, 32'd0);
    end
    repeat (2) @(posedge clk); #1;

    chk("done_queue_empty", 32'(dq.size()), 32'd0);
    chk("write_queue_empty", 32'(wq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
